// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB-first, parity bit, stop bit.
// The latched word's parity is held on par until the next accepted load.
module parity_serial_tx #(
    parameter int WIDTH        = 4,
    parameter int ODD          = 0,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             par,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic          ODD_BIT  = (ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cyc_last_s;

    function automatic logic parity_of(input logic [WIDTH-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    // Line level for a given state; outputs are registered from the next state,
    // so they change on the same edge that changes the state.
    function automatic logic line_level(input state_t st, input logic lsb, input logic p);
        logic lvl;
        case (st)
            IDLE:    lvl = 1'b1;
            START:   lvl = 1'b0;
            DATA:    lvl = lsb;
            PARITY:  lvl = p;
            STOP:    lvl = 1'b1;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    // Next-state, counter, shift register and output computation.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        cyc_last_s = (cyc_q == CYC_LAST);

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    cyc_d   = '0;
                    bit_d   = '0;
                    shreg_d = s;
                    par_d   = parity_of(s, ODD_BIT);
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cyc_last_s) begin
                    state_d = DATA;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (cyc_last_s) begin
                    cyc_d   = '0;
                    shreg_d = shreg_q >> 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            PARITY: begin
                if (cyc_last_s) begin
                    state_d = STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            STOP: begin
                if (cyc_last_s) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
                shreg_d = '0;
            end
        endcase

        tx_d    = line_level(state_d, shreg_d[0], par_d);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign par   = par_q;
    assign done  = done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: expected frame bits are queued at load time
// and popped one per clock while the line is sampled on the falling edge.
module tb_parity_serial_tx;

    logic       clk;
    logic       rst;
    logic [3:0] s0, s1;
    logic       load0, load1;
    logic       ready0, tx0, busy0, par0, done0;
    logic       ready1, tx1, busy1, par1, done1;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    parity_serial_tx #(.WIDTH(4), .ODD(0), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst(rst), .s(s0), .load(load0),
        .ready(ready0), .tx(tx0), .busy(busy0), .par(par0), .done(done0)
    );

    parity_serial_tx #(.WIDTH(4), .ODD(1), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .s(s1), .load(load1),
        .ready(ready1), .tx(tx1), .busy(busy1), .par(par1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Sends one frame on dut0 (which=0) or dut1 (which=1), starting at a falling edge.
    // glitch_at >= 0 pulses load with 4'hF during that bit-cycle of the frame.
    task automatic send_frame(input int which, input logic [3:0] data, input int glitch_at);
        int   cpb;
        int   n;
        logic p;
        logic bv;
        logic expv;
        logic t, d, r, b, pr;
        cpb = (which == 0) ? 4 : 1;
        p   = (which == 0) ? ((data[0] + data[1] + data[2] + data[3]) % 2 == 1)
                           : ((data[0] + data[1] + data[2] + data[3]) % 2 == 0);
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      bv = 1'b0;
            else if (i <= 4) bv = data[i-1];
            else if (i == 5) bv = p;
            else             bv = 1'b1;
            for (int c = 0; c < cpb; c++) exp_q.push_back(bv);
        end
        if (which == 0) begin s0 = data; load0 = 1'b1; end
        else            begin s1 = data; load1 = 1'b1; end
        @(negedge clk);
        load0 = 1'b0; load1 = 1'b0;
        s0 = ~data; s1 = ~data;
        pr = (which == 0) ? par0 : par1;
        b  = (which == 0) ? busy0 : busy1;
        r  = (which == 0) ? ready0 : ready1;
        check($sformatf("par_latched_w%0d_s%h", which, data), pr, p);
        check($sformatf("busy_start_w%0d", which), b, 1'b1);
        check($sformatf("ready_start_w%0d", which), r, 1'b0);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            expv = exp_q.pop_front();
            t = (which == 0) ? tx0 : tx1;
            d = (which == 0) ? done0 : done1;
            check($sformatf("tx_w%0d_s%h_c%0d", which, data, k), t, expv);
            check($sformatf("done_low_w%0d_c%0d", which, k), d, 1'b0);
            if (which == 0 && k == glitch_at) begin
                load0 = 1'b1; s0 = 4'hF;
            end else begin
                load0 = 1'b0;
            end
            @(negedge clk);
        end
        load0 = 1'b0;
        t  = (which == 0) ? tx0 : tx1;
        d  = (which == 0) ? done0 : done1;
        r  = (which == 0) ? ready0 : ready1;
        pr = (which == 0) ? par0 : par1;
        check($sformatf("done_pulse_w%0d_s%h", which, data), d, 1'b1);
        check($sformatf("ready_after_w%0d", which), r, 1'b1);
        check($sformatf("tx_idle_w%0d", which), t, 1'b1);
        check($sformatf("par_hold_w%0d_s%h", which, data), pr, p);
    endtask

    initial begin
        rst = 1'b1; s0 = 4'h0; s1 = 4'h0; load0 = 1'b0; load1 = 1'b0;
        #2;
        check("reset_tx", tx0, 1'b1);
        check("reset_ready", ready0, 1'b1);
        check("reset_busy", busy0, 1'b0);
        check("reset_done", done0, 1'b0);
        check("reset_par", par0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_frame(0, 4'b0000, -1);
        @(negedge clk);
        check("done_single_cycle", done0, 1'b0);
        send_frame(0, 4'b1011, -1);
        @(negedge clk);
        for (int v = 0; v < 16; v++) begin
            send_frame(0, 4'(v), -1);
        end
        @(negedge clk);

        send_frame(1, 4'b0111, -1);
        send_frame(1, 4'b0000, -1);
        @(negedge clk);

        // load while busy is ignored
        send_frame(0, 4'b0001, 9);
        @(negedge clk);
        check("no_extra_frame_busy", busy0, 1'b0);
        check("no_extra_frame_tx", tx0, 1'b1);

        // back-to-back: second load applied during the done cycle
        send_frame(0, 4'b0110, -1);
        send_frame(0, 4'b1001, -1);
        @(negedge clk);

        // asynchronous reset in the middle of DATA
        s0 = 4'b0110; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", busy0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", tx0, 1'b1);
        check("async_rst_busy", busy0, 1'b0);
        check("async_rst_ready", ready0, 1'b1);
        check("async_rst_done", done0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_rst", done0, 1'b0);
        end
        send_frame(0, 4'b1101, -1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
